// File: rtl/hazard_controller.sv
// Load-use / forwarding / branch-flush controller for the 5-stage pipeline.
// Shadows the destinations of the instructions in EX and MEM next to the decode stage.
module hazard_controller #(
  parameter int unsigned REG_BITS     = 5,
  parameter int unsigned ZERO_REG     = 31,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_BITS-1:0]  id_rn,
  input  logic [REG_BITS-1:0]  id_rm,
  input  logic                 id_uses_rn,
  input  logic                 id_uses_rm,
  input  logic [REG_BITS-1:0]  id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  input  logic                 branch_taken,
  output logic                 stall,
  output logic                 flush,
  output logic                 fwd_a_ex,
  output logic                 fwd_b_ex,
  output logic                 fwd_a_mem,
  output logic                 fwd_b_mem,
  output logic                 ex_valid,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                regwrite;
  } dst_t;

  // memread only matters while the instruction sits in EX, so the MEM slot drops it.
  typedef struct packed {
    dst_t dst;
    logic memread;
  } ex_slot_t;

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  localparam logic [REG_BITS-1:0] ZERO_IDX   = REG_BITS'(ZERO_REG);
  localparam logic [2:0]          FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  ex_slot_t             ex_slot_q, ex_slot_d;
  dst_t                 mem_slot_q, mem_slot_d;
  state_e               state_q, state_d;
  logic [2:0]           fcnt_q, fcnt_d;
  logic                 fwd_a_ex_q, fwd_a_ex_d, fwd_b_ex_q, fwd_b_ex_d;
  logic                 fwd_a_mem_q, fwd_a_mem_d, fwd_b_mem_q, fwd_b_mem_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                 ma_ex, ma_mem, mb_ex, mb_mem, hz, bubble;

  function automatic logic writes(input dst_t s, input logic [REG_BITS-1:0] r);
    return s.valid & s.regwrite & (s.rd == r) & (s.rd != ZERO_IDX);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    ma_ex  = id_uses_rn & writes(ex_slot_q.dst, id_rn);
    ma_mem = id_uses_rn & writes(mem_slot_q, id_rn);
    mb_ex  = id_uses_rm & writes(ex_slot_q.dst, id_rm);
    mb_mem = id_uses_rm & writes(mem_slot_q, id_rm);
    hz     = id_valid & ex_slot_q.memread & (ma_ex | mb_ex);

    flush  = !reset & ((state_q == ST_RUN && branch_taken) || state_q == ST_FLUSH);
    stall  = hz & !flush & !reset;
    bubble = stall | flush | !id_valid;

    case (state_q)
      ST_RUN: begin
        if (branch_taken && FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_INIT;
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q - 3'd1;
        if (fcnt_q == 3'd1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    mem_slot_d = ex_slot_q.dst;
    if (bubble) begin
      ex_slot_d = '0;
    end else begin
      ex_slot_d.dst.valid    = 1'b1;
      ex_slot_d.dst.rd       = id_rd;
      ex_slot_d.dst.regwrite = id_regwrite;
      ex_slot_d.memread      = id_memread;
    end

    // EX/MEM result is newer than MEM/WB data, so it wins when both match.
    fwd_a_ex_d  = !bubble & ma_ex;
    fwd_b_ex_d  = !bubble & mb_ex;
    fwd_a_mem_d = !bubble & ma_mem & !ma_ex;
    fwd_b_mem_d = !bubble & mb_mem & !mb_ex;

    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    if (reset) begin
      ex_slot_q   <= '0;
      mem_slot_q  <= '0;
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      fwd_a_ex_q  <= 1'b0;
      fwd_b_ex_q  <= 1'b0;
      fwd_a_mem_q <= 1'b0;
      fwd_b_mem_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_slot_q   <= ex_slot_d;
      mem_slot_q  <= mem_slot_d;
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      fwd_a_ex_q  <= fwd_a_ex_d;
      fwd_b_ex_q  <= fwd_b_ex_d;
      fwd_a_mem_q <= fwd_a_mem_d;
      fwd_b_mem_q <= fwd_b_mem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_ex    = fwd_a_ex_q;
  assign fwd_b_ex    = fwd_b_ex_q;
  assign fwd_a_mem   = fwd_a_mem_q;
  assign fwd_b_mem   = fwd_b_mem_q;
  assign ex_valid    = ex_slot_q.dst.valid;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: each ID cycle pushes the expected
// EX-cycle result, which is popped and compared after the next rising edge.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rn, id_uses_rm, id_regwrite, id_memread, branch_taken;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        stall, flush, fwd_a_ex, fwd_b_ex, fwd_a_mem, fwd_b_mem, ex_valid;
  logic [15:0] stall_count, flush_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rn, rm, rd;
    logic       uses_rn, uses_rm, regwrite, memread;
  } instr_t;

  typedef struct packed {
    logic       stall, flush, exv;
    logic [3:0] fwd;  // {a_ex, a_mem, b_ex, b_mem}
  } exp_t;

  exp_t sb[$];

  hazard_controller #(.REG_BITS(5), .ZERO_REG(31), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex),
    .fwd_a_mem(fwd_a_mem), .fwd_b_mem(fwd_b_mem), .ex_valid(ex_valid),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic instr_t alu(input logic [4:0] rd, rn, rm);
    return '{valid: 1'b1, rn: rn, rm: rm, rd: rd, uses_rn: 1'b1, uses_rm: 1'b1,
             regwrite: 1'b1, memread: 1'b0};
  endfunction

  function automatic instr_t ldur(input logic [4:0] rd, rn);
    return '{valid: 1'b1, rn: rn, rm: 5'd0, rd: rd, uses_rn: 1'b1, uses_rm: 1'b0,
             regwrite: 1'b1, memread: 1'b1};
  endfunction

  function automatic instr_t cmp(input logic [4:0] rn, rm);
    return '{valid: 1'b1, rn: rn, rm: rm, rd: 5'd9, uses_rn: 1'b1, uses_rm: 1'b1,
             regwrite: 1'b0, memread: 1'b0};
  endfunction

  function automatic instr_t nop();
    return '0;
  endfunction

  task automatic drive(input instr_t i, input logic br);
    id_valid     = i.valid;
    id_rn        = i.rn;
    id_rm        = i.rm;
    id_rd        = i.rd;
    id_uses_rn   = i.uses_rn;
    id_uses_rm   = i.uses_rm;
    id_regwrite  = i.regwrite;
    id_memread   = i.memread;
    branch_taken = br;
  endtask

  // One ID cycle: stall/flush checked mid-cycle, registered EX view checked after the edge.
  task automatic step(input string nm, input instr_t i, input logic br,
                      input logic e_stall, input logic e_flush,
                      input logic e_exv, input logic [3:0] e_fwd);
    exp_t e;
    e.stall = e_stall; e.flush = e_flush; e.exv = e_exv; e.fwd = e_fwd;
    drive(i, br);
    sb.push_back(e);
    @(negedge clk);
    vectors++;
    if (stall !== sb[0].stall) begin
      miscompares++;
      $display("FAIL %s stall: got %b expected %b", nm, stall, sb[0].stall);
    end
    vectors++;
    if (flush !== sb[0].flush) begin
      miscompares++;
      $display("FAIL %s flush: got %b expected %b", nm, flush, sb[0].flush);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if (ex_valid !== e.exv) begin
      miscompares++;
      $display("FAIL %s ex_valid: got %b expected %b", nm, ex_valid, e.exv);
    end
    vectors++;
    if ({fwd_a_ex, fwd_a_mem, fwd_b_ex, fwd_b_mem} !== e.fwd) begin
      miscompares++;
      $display("FAIL %s fwd{a_ex,a_mem,b_ex,b_mem}: got %b expected %b", nm,
               {fwd_a_ex, fwd_a_mem, fwd_b_ex, fwd_b_mem}, e.fwd);
    end
  endtask

  task automatic drain();
    step("drain0", nop(), 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    step("drain1", nop(), 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  // Reset with a live load-use hazard and a taken branch on the inputs.
  task automatic apply_reset(input int n);
    reset = 1'b1;
    drive(alu(5'd6, 5'd5, 5'd5), 1'b1);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      vectors++;
      if ({stall, flush} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_comb{stall,flush}: got %b expected 00", {stall, flush});
      end
      @(posedge clk); #1;
      vectors++;
      if ({ex_valid, fwd_a_ex, fwd_a_mem, fwd_b_ex, fwd_b_mem} !== 5'b0 ||
          stall_count !== 16'd0 || flush_count !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_regs: exv/fwd=%b stall_count=%0d flush_count=%0d expected all 0",
                 {ex_valid, fwd_a_ex, fwd_a_mem, fwd_b_ex, fwd_b_mem}, stall_count, flush_count);
      end
    end
    reset = 1'b0;
    drive(nop(), 1'b0);
  endtask

  task automatic check_counts(input string nm, input int e_stall, input int e_flush);
    vectors++;
    if (stall_count !== 16'(e_stall)) begin
      miscompares++;
      $display("FAIL %s stall_count: got %0d expected %0d", nm, stall_count, e_stall);
    end
    vectors++;
    if (flush_count !== 16'(e_flush)) begin
      miscompares++;
      $display("FAIL %s flush_count: got %0d expected %0d", nm, flush_count, e_flush);
    end
  endtask

  task automatic test_reset();
    apply_reset(2);
    step("rst_idle", nop(), 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_counts("rst_counts", 0, 0);
  endtask

  task automatic test_forward_ex();
    drain();
    step("fex_add", alu(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("fex_sub", alu(5'd4, 5'd1, 5'd5), 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
  endtask

  task automatic test_forward_priority();
    drain();
    step("pri_add1", alu(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("pri_add2", alu(5'd1, 5'd4, 5'd5), 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("pri_orr",  alu(5'd7, 5'd1, 5'd1), 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
    drain();
    step("mem_add",  alu(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("mem_nop",  nop(),                 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    step("mem_orr",  alu(5'd7, 5'd1, 5'd1), 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);
  endtask

  task automatic test_load_use();
    drain();
    step("lu_ldur",  ldur(5'd5, 5'd0),      1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("lu_stall", alu(5'd6, 5'd4, 5'd5), 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    step("lu_add",   alu(5'd6, 5'd4, 5'd5), 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    check_counts("lu_counts", 1, 0);
  endtask

  task automatic test_zero_reg();
    drain();
    step("z_add31",  alu(5'd31, 5'd1, 5'd2),   1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("z_sub",    alu(5'd3, 5'd31, 5'd4),   1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("z_ldur31", ldur(5'd31, 5'd0),        1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("z_use31",  alu(5'd8, 5'd31, 5'd31),  1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("nw_cmp",   cmp(5'd1, 5'd2),          1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("nw_use",   alu(5'd10, 5'd9, 5'd9),   1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    check_counts("z_counts", 1, 0);
  endtask

  task automatic test_flush_over_stall();
    drain();
    step("fl_ldur", ldur(5'd5, 5'd0),      1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step("fl_br",   alu(5'd6, 5'd4, 5'd5), 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    step("fl_hold", alu(5'd6, 5'd4, 5'd5), 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    step("fl_run",  alu(5'd6, 5'd4, 5'd5), 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    check_counts("fl_counts", 1, 2);
  endtask

  task automatic test_reset_mid_flush();
    drain();
    step("mf_br", nop(), 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    apply_reset(1);
    step("mf_after", nop(), 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_counts("mf_counts", 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(nop(), 1'b0);
    test_reset();
    test_forward_ex();
    test_forward_priority();
    test_load_use();
    test_zero_reg();
    test_flush_over_stall();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
